// File: rtl/explosion_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | explosion_scheduler_if                                               |
// | Trigger handshake between the game logic and the explosion scheduler |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface explosion_scheduler_if;
   logic       trig_valid;
   logic       trig_ready;
   logic [9:0] trig_x;
   logic [9:0] trig_y;

   // Game logic side: raises requests and holds them until accepted
   modport master (
      output trig_valid,
      output trig_x,
      output trig_y,
      input  trig_ready
   );

   // Scheduler side: accepts requests when a slot is free
   modport slave (
      input  trig_valid,
      input  trig_x,
      input  trig_y,
      output trig_ready
   );
endinterface
`default_nettype wire

// File: rtl/explosion_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | explosion_scheduler                                                  |
// | Allocates explosion triggers to animation slots, advances each slot  |
// | on frame boundaries and resolves per-pixel sprite hits.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module explosion_scheduler #(
   parameter int SLOTS  = 4,
   parameter int SPRITE = 32,
   parameter int FRAMES = 3,
   parameter int HOLD   = 8
) (
   input  wire logic                 vga_clk,
   input  wire logic                 reset_n,
   input  wire logic                 frame_start,
   explosion_scheduler_if.slave      trig,
   input  wire logic [9:0]           DrawX,
   input  wire logic [9:0]           DrawY,
   output logic      [SLOTS-1:0]     busy,
   output logic                      exp_on,
   output logic      [1:0]           exp_stage,
   output logic      [9:0]           rom_address
);

   localparam logic [7:0]  c_hold_last  = 8'(HOLD - 1);
   localparam logic [1:0]  c_stage_last = 2'(FRAMES - 1);
   localparam logic [10:0] c_sprite11   = 11'(SPRITE);
   localparam logic [9:0]  c_sprite10   = 10'(SPRITE);

   typedef enum logic [0:0] {
      SLOT_IDLE   = 1'b0,
      SLOT_ACTIVE = 1'b1
   } slot_state_e;

   slot_state_e state_q [SLOTS];
   slot_state_e state_d [SLOTS];
   logic [1:0]  stage_q [SLOTS];
   logic [1:0]  stage_d [SLOTS];
   logic [7:0]  hold_q  [SLOTS];
   logic [7:0]  hold_d  [SLOTS];
   logic [9:0]  x_q     [SLOTS];
   logic [9:0]  x_d     [SLOTS];
   logic [9:0]  y_q     [SLOTS];
   logic [9:0]  y_d     [SLOTS];

   logic             exp_on_q;
   logic             exp_on_d;
   logic [1:0]       exp_stage_q;
   logic [1:0]       exp_stage_d;
   logic [9:0]       rom_address_q;
   logic [9:0]       rom_address_d;

   logic [SLOTS-1:0] w_free;
   logic [SLOTS-1:0] w_alloc;
   logic             w_accept;
   logic [SLOTS-1:0] w_hit;
   logic [9:0]       w_addr [SLOTS];

   // Per-slot status and pixel hit test; bounds compared at 11 bits so a
   // sprite near the right/bottom edge clips instead of wrapping to 0.
   for (genvar s = 0; s < SLOTS; s++) begin : g_slot
      logic [10:0] w_px;
      logic [10:0] w_py;
      logic [10:0] w_lo_x;
      logic [10:0] w_lo_y;
      logic [9:0]  w_off_x;
      logic [9:0]  w_off_y;

      assign w_free[s] = (state_q[s] == SLOT_IDLE);
      assign busy[s]   = (state_q[s] == SLOT_ACTIVE);

      assign w_px    = {1'b0, DrawX};
      assign w_py    = {1'b0, DrawY};
      assign w_lo_x  = {1'b0, x_q[s]};
      assign w_lo_y  = {1'b0, y_q[s]};
      assign w_off_x = DrawX - x_q[s];
      assign w_off_y = DrawY - y_q[s];

      assign w_hit[s] = busy[s]
                        && (w_px >= w_lo_x) && (w_px < w_lo_x + c_sprite11)
                        && (w_py >= w_lo_y) && (w_py < w_lo_y + c_sprite11);
      assign w_addr[s] = w_off_y * c_sprite10 + w_off_x;
   end

   assign trig.trig_ready = |w_free;
   assign w_accept        = trig.trig_valid & trig.trig_ready;

   // Lowest-index idle slot receives the next accepted trigger
   always_comb begin
      w_alloc = '0;
      for (int s = SLOTS - 1; s >= 0; s--) begin
         if (w_free[s]) begin
            w_alloc    = '0;
            w_alloc[s] = 1'b1;
         end
      end
   end

   // Slot next-state: load on accept, advance hold/stage on frame_start, expire at end
   always_comb begin
      for (int s = 0; s < SLOTS; s++) begin
         state_d[s] = state_q[s];
         stage_d[s] = stage_q[s];
         hold_d[s]  = hold_q[s];
         x_d[s]     = x_q[s];
         y_d[s]     = y_q[s];
         case (state_q[s])
            SLOT_IDLE: begin
               if (w_accept && w_alloc[s]) begin
                  state_d[s] = SLOT_ACTIVE;
                  stage_d[s] = 2'd0;
                  hold_d[s]  = 8'd0;
                  x_d[s]     = trig.trig_x;
                  y_d[s]     = trig.trig_y;
               end
            end
            SLOT_ACTIVE: begin
               if (frame_start) begin
                  if (hold_q[s] == c_hold_last) begin
                     hold_d[s] = 8'd0;
                     if (stage_q[s] == c_stage_last) begin
                        state_d[s] = SLOT_IDLE;
                        stage_d[s] = 2'd0;
                     end else begin
                        stage_d[s] = stage_q[s] + 2'd1;
                     end
                  end else begin
                     hold_d[s] = hold_q[s] + 8'd1;
                  end
               end
            end
            default: state_d[s] = SLOT_IDLE;
         endcase
      end
   end

   // Pixel result: lowest-index hitting slot wins, zeros when nothing hits
   always_comb begin
      exp_on_d      = 1'b0;
      exp_stage_d   = 2'd0;
      rom_address_d = 10'd0;
      for (int s = SLOTS - 1; s >= 0; s--) begin
         if (w_hit[s]) begin
            exp_on_d      = 1'b1;
            exp_stage_d   = stage_q[s];
            rom_address_d = w_addr[s];
         end
      end
   end

   // State and output registers; reset aborts every animation immediately
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SLOTS; s++) begin
            state_q[s] <= SLOT_IDLE;
            stage_q[s] <= 2'd0;
            hold_q[s]  <= 8'd0;
            x_q[s]     <= 10'd0;
            y_q[s]     <= 10'd0;
         end
         exp_on_q      <= 1'b0;
         exp_stage_q   <= 2'd0;
         rom_address_q <= 10'd0;
      end else begin
         for (int s = 0; s < SLOTS; s++) begin
            state_q[s] <= state_d[s];
            stage_q[s] <= stage_d[s];
            hold_q[s]  <= hold_d[s];
            x_q[s]     <= x_d[s];
            y_q[s]     <= y_d[s];
         end
         exp_on_q      <= exp_on_d;
         exp_stage_q   <= exp_stage_d;
         rom_address_q <= rom_address_d;
      end
   end

   assign exp_on      = exp_on_q;
   assign exp_stage   = exp_stage_q;
   assign rom_address = rom_address_q;

endmodule
`default_nettype wire

// File: doc/explosion_scheduler.md
Name: explosion_scheduler

Overview:
- Sequences up to SLOTS simultaneous explosion animations for the game.
- Accepts trigger requests (screen position of a hit), allocates each to a free slot, and advances each slot through FRAMES animation stages on frame boundaries.
- Per pixel, decides whether (DrawX, DrawY) falls inside an active explosion. If so, it supplies the stage index and sprite-local ROM address that the explosion sprite ROM and palette datapath consume.
- Sits between game logic (trigger source) and the explosion sprite ROMs in the vga_clk domain.

Parameters:
- SLOTS, 4, number of concurrent explosions (1..8)
- SPRITE, 32, sprite side length in pixels (power of two, SPRITE*SPRITE <= 1024)
- FRAMES, 3, animation stages per explosion (1..4)
- HOLD, 8, frame_start pulses each stage is displayed (1..255)

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse once per video frame (vsync)
- trig_valid  in  1  explosion request
- trig_ready  out  1  high when at least one slot is free
- trig_x  in  10  sprite top-left X (0..639)
- trig_y  in  10  sprite top-left Y (0..479)
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- busy  out  SLOTS  per-slot active flags
- exp_on  out  1  current (delayed) pixel lies inside an active explosion
- exp_stage  out  2  animation stage of the winning slot
- rom_address  out  10  sprite-local address (row*SPRITE + col)

Behaviour:
- Reset (reset_n low, async):
  - all slots IDLE; stage, hold counter and position cleared
  - busy=0, exp_on=0, exp_stage=0, rom_address=0
  - trig_ready=1 once reset_n deasserts
- Slot state machine, per slot:
  - IDLE -> ACTIVE on accepted trigger; load x, y; stage=0; hold=0.
  - ACTIVE, on frame_start: if hold==HOLD-1, set hold=0 and stage++; else hold++.
  - ACTIVE, on frame_start: if hold==HOLD-1 and stage==FRAMES-1, the slot goes to IDLE instead.
  - Total active lifetime: exactly FRAMES*HOLD frame_start pulses.
- Handshake:
  - Accept on trig_valid && trig_ready.
  - trig_ready = OR of ~busy, combinational from registered state.
  - The accepted request goes to the lowest-index IDLE slot.
  - trig_valid while not ready is ignored (not queued); the requester must hold it.
- Simultaneous events:
  - A trigger accepted in the same cycle as frame_start loads stage 0, hold 0; that pulse does not advance the new slot.
  - A slot freed by frame_start becomes visible to trig_ready on the next cycle only.
- busy = registered slot-active bits; it updates one cycle after the accept or expiry edge.
- Pixel path, 1-cycle latency (outputs registered, aligned with the 1-cycle synchronous ROM stage of the sprite datapath):
  - Slot s hits when x_s <= DrawX < x_s+SPRITE and y_s <= DrawY < y_s+SPRITE.
  - Comparisons are done at 11 bits, so sprites near the right or bottom edge clip correctly and never wrap.
  - Priority: the lowest-index hitting slot wins.
  - On a hit: exp_on=1, exp_stage=stage_s, rom_address=(DrawY-y_s)*SPRITE+(DrawX-x_s), truncated to 10 bits.
  - No hit: exp_on=0, exp_stage=0, rom_address=0.
- A slot accepted in cycle N affects pixel outputs starting with DrawX/DrawY sampled in cycle N+1.
- Reset mid-animation: all slots abort immediately and outputs go to 0 asynchronously.

Test Plan:
- Reset then single trigger (x=100, y=50), HOLD=8, FRAMES=3:
  - busy=0001 the cycle after accept.
  - exp_stage steps 0->1->2 after the 8th and 16th frame_start.
  - busy=0000 after the 24th frame_start.
- Pixel mapping for slot at (100, 50):
  - DrawX=131, DrawY=81 -> next cycle exp_on=1, rom_address=1023.
  - DrawX=132 -> exp_on=0, rom_address=0.
  - DrawX=99 -> exp_on=0.
- Fill all 4 slots with back-to-back triggers:
  - trig_ready drops after the 4th accept; a 5th held trig_valid stays pending.
  - Once slot 0 expires, the held request is accepted into slot 0 the cycle after expiry.
- Overlap: slot0 at (200, 200) stage 1, slot2 at (210, 210) stage 0; pixel (215, 215) -> exp_stage=1, rom_address=15*32+15=495 (slot 0 wins).
- Edge clip: trigger at (620, 470); pixel (639, 479) -> exp_on=1, rom_address=9*32+19=307; no hit reported at pixel (0, 0).
- Trigger coincident with frame_start, and reset_n pulsed low mid-animation:
  - The new slot starts at stage 0 with hold 0.
  - The reset pulse clears busy and exp_on with no clock edge required.
